// File: rtl/adc_idelay_sequencer.sv
`timescale 1ns/1ps
// Converts absolute IDELAY tap targets into paced single-cycle CE trains on one of nine
// ADC delay lines, tracks every line's tap, and issues global IDELAY resets.
module adc_idelay_sequencer #(
    parameter int CE_GAP  = 4,
    parameter int RST_LEN = 4,
    parameter int TAP_W   = 6
) (
    input  logic             clk40,
    input  logic             rst_n,
    input  logic             run,
    input  logic             idelayctrl_rdy,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_adc,
    input  logic [1:0]       req_line,
    input  logic [TAP_W-1:0] req_taps,
    input  logic             rst_all,
    output logic [8:0]       delay_ce,
    output logic             idelay_rst,
    output logic             busy,
    output logic             done,
    output logic             err,
    input  logic [3:0]       rd_sel,
    output logic [TAP_W-1:0] rd_taps
);

    localparam int GAP_W = (CE_GAP > 2) ? $clog2(CE_GAP - 1) : 1;
    localparam int RST_W = (RST_LEN > 1) ? $clog2(RST_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_PULSE, S_GAP, S_RSTP, S_WRDY, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         adc_q, line_q;
    logic [TAP_W-1:0]   target_q, cnt_q, cur_tap;
    logic [GAP_W-1:0]   gap_q;
    logic [RST_W-1:0]   rst_q;
    logic [TAP_W-1:0]   taps [9];
    logic [3:0]         idx;
    logic               req_bad, ce_fire;

    // Handshake: a request transfers on a rising clk40 edge where req_valid & req_ready;
    // req_valid may assert at any time, req_ready never depends on req_valid.
    assign req_ready = (state_q == S_IDLE) && !run && idelayctrl_rdy && !rst_all;

    assign idx     = 4'(adc_q) * 4'd3 + 4'(line_q);
    assign req_bad = (adc_q == 2'd3) || (line_q == 2'd3);
    assign ce_fire = (state_q == S_PULSE) && !run;
    assign busy    = (state_q != S_IDLE);

    always_comb begin
        cur_tap  = '0;
        rd_taps  = '0;
        delay_ce = '0;
        for (int i = 0; i < 9; i++) begin
            if (idx == 4'(i)) cur_tap = taps[i];
            if (rd_sel == 4'(i)) rd_taps = taps[i];
            delay_ce[i] = ce_fire && (idx == 4'(i));
        end
    end

    always_ff @(posedge clk40 or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        done       = 1'b0;
        err        = 1'b0;
        idelay_rst = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rst_all)                     state_d = S_RSTP;
                else if (req_valid && req_ready) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (req_bad) begin
                    err     = 1'b1;
                    state_d = S_IDLE;
                end else if (target_q == cur_tap) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_PULSE;
                end
            end
            S_PULSE: if (!run) state_d = S_GAP;
            S_GAP: begin
                if (gap_q == '0) state_d = (cnt_q == '0) ? S_DONE : S_PULSE;
            end
            S_RSTP: begin
                idelay_rst = 1'b1;
                if (rst_q == '0) state_d = S_WRDY;
            end
            S_WRDY: if (idelayctrl_rdy) state_d = S_DONE;
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request latch plus the step, gap and reset-width counters.
    always_ff @(posedge clk40 or negedge rst_n) begin
        if (!rst_n) begin
            adc_q    <= '0;
            line_q   <= '0;
            target_q <= '0;
            cnt_q    <= '0;
            gap_q    <= '0;
            rst_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        adc_q    <= req_adc;
                        line_q   <= req_line;
                        target_q <= req_taps;
                    end
                    rst_q <= RST_W'(RST_LEN - 1);
                end
                S_LOAD: cnt_q <= target_q - cur_tap;
                S_PULSE: begin
                    if (!run) begin
                        cnt_q <= cnt_q - 1'b1;
                        gap_q <= GAP_W'(CE_GAP - 2);
                    end
                end
                S_GAP:  if (gap_q != '0) gap_q <= gap_q - 1'b1;
                S_RSTP: if (rst_q != '0) rst_q <= rst_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Tap counters wrap modulo 2^TAP_W; a global reset zeroes them while idelay_rst is high.
    always_ff @(posedge clk40 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) taps[i] <= '0;
        end else if (state_q == S_RSTP) begin
            for (int i = 0; i < 9; i++) taps[i] <= '0;
        end else if (ce_fire) begin
            for (int i = 0; i < 9; i++)
                if (idx == 4'(i)) taps[i] <= taps[i] + 1'b1;
        end
    end

endmodule

// File: doc/adc_idelay_sequencer.md
Name: adc_idelay_sequencer

Overview:
- Owns the nine ADC IDELAY increment strobes: drdy, clk and data lines for each of ADC1-3.
- Accepts absolute tap-target requests over a valid/ready port and converts each into a paced train of single-cycle CE pulses on the selected delay line.
- Tracks the current tap of every line and issues global IDELAY resets.
- Blocks and pauses adjustment while the acquisition `run` is active, so delays never move during a stored pulse train.

Parameters:
- CE_GAP, 4: minimum clk40 cycles from one CE pulse's rising edge to the next (>=2).
- RST_LEN, 4: idelay_rst pulse width in cycles.
- TAP_W, 6: tap counter width; taps wrap modulo 2^TAP_W (64).

Ports:
- clk40  in  1  control clock; all logic on rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- run  in  1  acquisition active; blocks acceptance and pauses CE issue.
- idelayctrl_rdy  in  1  IDELAYCTRL ready.
- req_valid  in  1  adjust request valid.
- req_ready  out  1  request accepted when valid&ready.
- req_adc  in  2  ADC select: 0,1,2 = ADC1-3; 3 invalid.
- req_line  in  2  line select: 0=drdy, 1=clk, 2=data; 3 invalid.
- req_taps  in  TAP_W  absolute target tap.
- rst_all  in  1  request global IDELAY reset; level-sampled in IDLE.
- delay_ce  out  9  CE strobes; bit = adc*3+line (bit0 = adc1_drdy ... bit8 = adc3_data).
- idelay_rst  out  1  IDELAY reset pulse.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse on an accepted invalid request.
- rd_sel  in  4  readback select, 0-8.
- rd_taps  out  TAP_W  current tap of line rd_sel; combinational; 0 for rd_sel > 8.

Behaviour:
- Reset values (rst_n low, asynchronous):
  - delay_ce=0, idelay_rst=0, busy=0, done=0, err=0.
  - All nine tap registers = 0; state=IDLE.
  - A reset mid-train drops CE immediately; the aborted train is lost.
- req_ready = (state==IDLE) & ~run & idelayctrl_rdy & ~rst_all.
- States: IDLE, LOAD, PULSE, GAP, RSTP, WRDY, DONE.
- IDLE transitions:
  - rst_all=1 → RSTP; rst_all has priority over req_valid in the same cycle, and the request is not accepted.
  - Otherwise on valid&ready, latch adc, line and target → LOAD.
- LOAD (1 cycle):
  - If adc==3 or line==3: err=1 for one cycle, → IDLE; no CE, no tap change.
  - Else cnt = (target - cur[idx]) mod 2^TAP_W.
  - cnt==0 → DONE.
  - Else → PULSE.
- PULSE:
  - If run==0: delay_ce[idx]=1 for exactly one cycle, cur[idx] += 1 (63→0 wrap), cnt -= 1, → GAP.
  - If run==1: hold in PULSE with CE low (pause).
- GAP:
  - Held CE_GAP-1 cycles with CE low.
  - Then cnt==0 → DONE, else → PULSE.
  - Pulses therefore have a minimum period of CE_GAP.
- RSTP:
  - idelay_rst=1 for RST_LEN cycles.
  - All tap registers cleared to 0 on the first RSTP cycle.
  - Then → WRDY.
- WRDY: wait for idelayctrl_rdy=1, then → DONE.
- DONE: done=1 for one cycle → IDLE. req_ready can reassert the following cycle.
- Latency for a valid request with N>0 steps: accept at cycle 0, LOAD at cycle 1, first CE at cycle 2, done at cycle 2 + (N-1)·CE_GAP + CE_GAP.
- Latency for N=0: done at cycle 2.
- Only one delay_ce bit is ever high, and never together with idelay_rst.
- rd_taps reflects each increment in the cycle after its CE.

Test Plan:
- Reset; request adc=1, line=2, target=5 with run=0 → 5 single-cycle pulses on delay_ce[5] at cycles 2, 6, 10, 14, 18; done at cycle 22; rd_sel=5 gives rd_taps=5.
- Set line0 of ADC1 to 60, then request target 2 → exactly 6 pulses on delay_ce[0]; rd_taps goes 61, 62, 63, 0, 1, 2.
- Request target equal to the current tap (5) → no CE; done at cycle 2 after accept; busy high for 2 cycles.
- Target 8 from 0; raise run after the 2nd CE and hold 20 cycles → no CE while run=1; remaining 6 pulses follow; req_ready stays 0 throughout.
- req_line=3 accepted → err pulse at cycle 1, no CE, all taps unchanged, req_ready back the following cycle.
- rst_all with req_valid in the same cycle → request not accepted; idelay_rst high 4 cycles; all taps 0; done only after idelayctrl_rdy rises. Separately, pulse rst_n low mid-train → delay_ce goes 0 without waiting for clk40.
